pet_needs_scheduler: RTL and testbench

//  Owns the pet's need registers (food, fun, rest, life) and sequences their periodic update.

---
 rtl/pet_pkg.sv | 67 ++++++
 rtl/pet_tick_gen.sv | 26 ++
 rtl/pet_needs_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_pet_needs_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pet_pkg.sv
// pet_pkg: shared definitions for the pet needs scheduler, the menu FSM and
// the OLED needs display.
//   - act_e    : care action codes (also the action output encoding)
//   - state_e  : scheduler FSM states
//   - need thresholds and saturation ceiling
//   - pick_grant / act_need helpers
package pet_pkg;

  typedef enum logic [1:0] {
    ACT_PLAY  = 2'd0,
    ACT_EAT   = 2'd1,
    ACT_SLEEP = 2'd2,
    ACT_HEAL  = 2'd3
  } act_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_UPDATE = 3'd2,
    ST_LIFE   = 3'd3,
    ST_DEAD   = 3'd4
  } state_e;

  localparam int NEED_W    = 7;
  localparam int NUM_NEEDS = 3;  // food, fun, rest; life is handled separately
  localparam int N_FOOD    = 0;
  localparam int N_FUN     = 1;
  localparam int N_REST    = 2;

  localparam logic [NEED_W-1:0] NEED_MAX   = 7'd100;
  localparam logic [NEED_W-1:0] LIFE_PLUS  = 7'd70;
  localparam logic [NEED_W-1:0] LIFE_MINUS = 7'd30;
  localparam logic [NEED_W-1:0] DISEASE_TH = 7'd20;
  localparam logic signed [8:0] NEED_MAX_S = 9'sd100;

  typedef struct packed {
    logic vld;
    act_e act;
  } grant_t;

  // Fixed priority heal > eat > sleep > play; heal only while diseased.
  // req bit order is {heal, sleep, eat, play}.
  function automatic grant_t pick_grant(input logic [3:0] req, input logic disease);
    grant_t g;
    g.vld = 1'b1;
    if (req[3] && disease) g.act = ACT_HEAL;
    else if (req[1])       g.act = ACT_EAT;
    else if (req[2])       g.act = ACT_SLEEP;
    else if (req[0])       g.act = ACT_PLAY;
    else begin
      g.vld = 1'b0;
      g.act = ACT_PLAY;
    end
    return g;
  endfunction

  // Need lane served by an action; heal serves no lane (returns 3).
  function automatic logic [1:0] act_need(input act_e a);
    case (a)
      ACT_PLAY:  return 2'(N_FUN);
      ACT_EAT:   return 2'(N_FOOD);
      ACT_SLEEP: return 2'(N_REST);
      default:   return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// pet_tick_gen: free-running divider, one-cycle tick every TICK_CYCLES clocks.
//   clk   in  system clock
//   rst_n in  async active-low reset
//   tick  out high on the cycle the counter sits at TICK_CYCLES-1
module pet_tick_gen #(
  parameter int TICK_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/pet_needs_scheduler.sv
// pet_needs_scheduler: owns the pet need registers and sequences their
// periodic update, arbitrates care actions and derives disease/death.
//   clk        in   system clock
//   btn_reset  in   async active-low reset (synchronised release)
//   req[3:0]   in   action request levels {heal,sleep,eat,play}, held until ack
//   cancel     in   one-cycle pulse, aborts the running action
//   ack[3:0]   out  one-cycle one-hot grant
//   busy       out  action active
//   action     out  active action code, valid while busy
//   food/fun/rest/life out need values 0..NEED_MAX
//   disease    out  life <= DISEASE_TH
//   death      out  life reached 0, sticky
//   tick       out  update tick pulse
//
// Timing per tick (tick seen in cycle T):
//   edge ending T   : food/fun/rest update, FSM -> UPDATE
//   edge ending T+1 : life/disease/death update, FSM -> LIFE
//   edge ending T+2 : FSM returns to IDLE/ACTIVE or enters DEAD
// TICK_CYCLES must be >= 3 so a tick never lands inside UPDATE/LIFE.
module pet_needs_scheduler
  import pet_pkg::*;
#(
  parameter int TICK_CYCLES  = 5_000_000,
  parameter int DECAY_TICKS  = 1,
  parameter int ACTION_TICKS = 20,
  parameter int ACTION_GAIN  = 2,
  parameter int HEAL_GAIN    = 5
) (
  input  logic              clk,
  input  logic              btn_reset,
  input  logic [3:0]        req,
  input  logic              cancel,
  output logic [3:0]        ack,
  output logic              busy,
  output logic [1:0]        action,
  output logic [NEED_W-1:0] food,
  output logic [NEED_W-1:0] fun,
  output logic [NEED_W-1:0] rest,
  output logic [NEED_W-1:0] life,
  output logic              disease,
  output logic              death,
  output logic              tick
);

  localparam int DCW    = $clog2(DECAY_TICKS + 1);
  localparam int ACW    = $clog2(ACTION_TICKS + 1);
  localparam int GAIN_W = NEED_W + 1;
  localparam logic [GAIN_W-1:0] GAIN   = GAIN_W'(ACTION_GAIN);
  localparam logic signed [8:0] HEAL_D = 9'(HEAL_GAIN);
  localparam logic [ACW-1:0]    ACT_N  = ACW'(ACTION_TICKS);

  // reset: async assert, release synchronised to clk
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  pet_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  state_e                               state_q, state_d;
  logic [NUM_NEEDS-1:0][NEED_W-1:0]     needs_q;
  logic [NEED_W-1:0]                    life_q, life_new;
  logic                                 busy_q, busy_d;
  act_e                                 act_q;
  logic [3:0]                           ack_q;
  logic                                 disease_q, death_q, cancel_lat_q;
  logic [ACW-1:0]                       act_cnt_q;
  grant_t                               grant;
  logic                                 do_grant, do_update, do_life, end_act;
  logic signed [8:0]                    delta, life_sum;

  assign grant     = pick_grant(req, disease_q);
  assign do_grant  = (state_q == ST_IDLE) && !tick && grant.vld;
  assign do_update = tick && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
  assign do_life   = (state_q == ST_UPDATE);
  // a cancel arriving in LIFE itself is honoured on the same return
  assign end_act   = cancel_lat_q || cancel || (act_cnt_q >= ACT_N);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (tick) state_d = ST_UPDATE;
                 else if (grant.vld) state_d = ST_ACTIVE;
      ST_ACTIVE: if (tick) state_d = ST_UPDATE;
                 else if (cancel) state_d = ST_IDLE;
      ST_UPDATE: state_d = ST_LIFE;
      ST_LIFE:   if (life_q == '0) state_d = ST_DEAD;
                 else if (busy_q && !end_act) state_d = ST_ACTIVE;
                 else state_d = ST_IDLE;
      ST_DEAD:   state_d = ST_DEAD;
      default:   state_d = ST_IDLE;
    endcase
  end

  // busy spans the UPDATE/LIFE detour of an action
  assign busy_d = (state_d == ST_ACTIVE) ||
                  (busy_q && ((state_d == ST_UPDATE) || (state_d == ST_LIFE)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      act_q        <= ACT_PLAY;
      ack_q        <= '0;
      act_cnt_q    <= '0;
      cancel_lat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ack_q   <= do_grant ? (4'b0001 << grant.act) : 4'b0000;
      if (do_grant) act_q <= grant.act;
      if (do_grant)                 act_cnt_q <= '0;
      else if (do_update && busy_q) act_cnt_q <= act_cnt_q + 1'b1;
      // cancel that collides with the tick detour is held until the return
      if (state_q == ST_LIFE)
        cancel_lat_q <= 1'b0;
      else if (cancel && ((state_q == ST_UPDATE) || (state_q == ST_ACTIVE && tick)))
        cancel_lat_q <= 1'b1;
    end
  end

  // food/fun/rest lanes
  for (genvar g = 0; g < NUM_NEEDS; g++) begin : g_need
    logic [NEED_W-1:0] need_r;
    logic [DCW-1:0]    dcnt_r;
    logic [GAIN_W-1:0] sum;
    logic              serve;

    assign serve = busy_q && (act_need(act_q) == 2'(g));
    assign sum   = {1'b0, need_r} + GAIN;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        need_r <= NEED_MAX;
        dcnt_r <= '0;
      end else if (do_update) begin
        if (serve) begin
          need_r <= (sum > {1'b0, NEED_MAX}) ? NEED_MAX : sum[NEED_W-1:0];
          dcnt_r <= '0;
        end else if (dcnt_r == DCW'(DECAY_TICKS - 1)) begin
          need_r <= (need_r == '0) ? '0 : need_r - 1'b1;
          dcnt_r <= '0;
        end else begin
          dcnt_r <= dcnt_r + 1'b1;
        end
      end
    end

    assign needs_q[g] = need_r;
  end

  // life step from the post-update need values
  always_comb begin
    delta = 9'sd0;
    for (int i = 0; i < NUM_NEEDS; i++) begin
      if (needs_q[i] >= LIFE_PLUS)  delta = delta + 9'sd1;
      if (needs_q[i] <= LIFE_MINUS) delta = delta - 9'sd1;
    end
    if (busy_q && (act_q == ACT_HEAL)) delta = delta + HEAL_D;
    life_sum = $signed({2'b00, life_q}) + delta;
    if (life_sum[8])               life_new = '0;
    else if (life_sum > NEED_MAX_S) life_new = NEED_MAX;
    else                           life_new = life_sum[NEED_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      life_q    <= NEED_MAX;
      disease_q <= 1'b0;
      death_q   <= 1'b0;
    end else if (do_life) begin
      life_q    <= life_new;
      disease_q <= (life_new <= DISEASE_TH);
      death_q   <= death_q | (life_new == '0);
    end
  end

  assign ack     = ack_q;
  assign busy    = busy_q;
  assign action  = act_q;
  assign food    = needs_q[N_FOOD];
  assign fun     = needs_q[N_FUN];
  assign rest    = needs_q[N_REST];
  assign life    = life_q;
  assign disease = disease_q;
  assign death   = death_q;

endmodule

// File: tb/tb_pet_needs_scheduler.sv
module tb_pet_needs_scheduler;

  logic       clk = 1'b0;
  logic       btn_reset = 1'b0;
  logic [3:0] req = 4'b0;
  logic       cancel = 1'b0;
  logic [3:0] ack;
  logic       busy, disease, death, tick;
  logic [1:0] action;
  logic [6:0] food, fun, rest, life;

  pet_needs_scheduler #(.TICK_CYCLES(4)) dut (
    .clk(clk), .btn_reset(btn_reset), .req(req), .cancel(cancel),
    .ack(ack), .busy(busy), .action(action),
    .food(food), .fun(fun), .rest(rest), .life(life),
    .disease(disease), .death(death), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tno;
    logic [6:0] food, fun, rest, life;
    logic       dis, dth, busy2, busy3;
  } snap_t;
  typedef struct {
    logic [3:0] ack;
    logic [1:0] act;
  } ackx_t;

  snap_t snapq[$];
  ackx_t ackq[$];
  int n_chk = 0, n_fail = 0;
  int scnt = 0;

  task automatic snap(input int t, input int fo, input int fu, input int re, input int li,
                      input bit di, input bit dt, input bit b2, input bit b3);
    snap_t s;
    s.tno = t; s.food = 7'(fo); s.fun = 7'(fu); s.rest = 7'(re); s.life = 7'(li);
    s.dis = di; s.dth = dt; s.busy2 = b2; s.busy3 = b3;
    snapq.push_back(s);
  endtask

  task automatic exp_ack(input logic [3:0] a, input logic [1:0] c);
    ackx_t e;
    e.ack = a; e.act = c;
    ackq.push_back(e);
  endtask

  // monitor: ack grants and per-tick snapshots three cycles after each tick
  int   tcnt = 0, dly = 0;
  logic b2_seen = 1'b0;
  always @(negedge clk) begin
    if (!btn_reset) begin
      tcnt = 0; dly = 0;
    end else begin
      if (ack != 4'b0) begin
        n_chk++;
        if (ackq.size() == 0) begin
          n_fail++;
          $display("FAIL ack_unexpected: got ack=%b action=%0d, required no ack", ack, action);
        end else begin
          ackx_t e;
          e = ackq.pop_front();
          if (ack !== e.ack || action !== e.act || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_grant: got ack=%b action=%0d busy=%b, required ack=%b action=%0d busy=1",
                     ack, action, busy, e.ack, e.act);
          end
        end
      end
      if (tick) begin
        tcnt++; dly = 3;
      end else if (dly > 0) begin
        dly--;
        if (dly == 1) b2_seen = busy;
        if (dly == 0 && snapq.size() > 0 && snapq[0].tno <= tcnt) begin
          snap_t s;
          s = snapq.pop_front();
          n_chk++;
          if (s.tno != tcnt) begin
            n_fail++;
            $display("FAIL snap_missed: tick %0d snapshot not taken, now at tick %0d", s.tno, tcnt);
          end else if ({food, fun, rest, life, disease, death, b2_seen, busy} !==
                       {s.food, s.fun, s.rest, s.life, s.dis, s.dth, s.busy2, s.busy3}) begin
            n_fail++;
            $display("FAIL snap_t%0d: got food=%0d fun=%0d rest=%0d life=%0d dis=%b dth=%b busy@2=%b busy@3=%b, required %0d %0d %0d %0d %b %b %b %b",
                     tcnt, food, fun, rest, life, disease, death, b2_seen, busy,
                     s.food, s.fun, s.rest, s.life, s.dis, s.dth, s.busy2, s.busy3);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (tick) scnt++;
  endtask

  task automatic wait_tick(input int k);
    int g = 0;
    while (scnt < k && g < 2000) begin step(); g++; end
    if (scnt < k) begin
      n_chk++; n_fail++;
      $display("FAIL wait_tick: reached tick %0d, required tick %0d", scnt, k);
    end
  endtask

  task automatic wait_ack();
    int g = 0;
    do begin step(); g++; end while (ack == 4'b0 && g < 200);
    if (ack == 4'b0) begin
      n_chk++; n_fail++;
      $display("FAIL wait_ack: no ack within 200 cycles, req=%b", req);
    end
  endtask

  task automatic check_reset(input string nm);
    n_chk++;
    if ({food, fun, rest, life} !== {7'd100, 7'd100, 7'd100, 7'd100} ||
        {disease, death, busy, ack, action, tick} !== 10'b0) begin
      n_fail++;
      $display("FAIL %s: got food=%0d fun=%0d rest=%0d life=%0d dis=%b dth=%b busy=%b ack=%b action=%0d tick=%b, required 100/100/100/100 and all flags 0",
               nm, food, fun, rest, life, disease, death, busy, ack, action, tick);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    btn_reset = 1'b1;
    scnt = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset_state");

    // decay run, then play, then eat with heal requested while healthy
    snap(1, 99, 99, 99, 100, 0, 0, 0, 0);
    snap(30, 70, 70, 70, 100, 0, 0, 0, 0);
    snap(31, 69, 69, 69, 100, 0, 0, 0, 0);
    snap(40, 60, 60, 60, 100, 0, 0, 0, 0);
    snap(41, 59, 62, 59, 100, 0, 0, 1, 1);
    snap(59, 41, 98, 41, 100, 0, 0, 1, 1);
    snap(60, 40, 100, 40, 100, 0, 0, 1, 0);
    snap(80, 80, 80, 20, 100, 0, 0, 1, 0);
    exp_ack(4'b0001, 2'd0);
    exp_ack(4'b0010, 2'd1);
    release_reset();
    wait_tick(40);
    req = 4'b0001;          // raised on a tick cycle: tick goes first
    wait_ack();
    req = 4'b0000;
    wait_tick(60);
    req = 4'b1010;
    wait_ack();
    req = 4'b1000;          // heal stays ineligible while healthy
    wait_tick(82);
    req = 4'b0000;

    // decay to sickness, heal, then decay to death
    btn_reset = 1'b0;
    repeat (3) @(negedge clk);
    snap(90, 10, 10, 10, 37, 0, 0, 0, 0);
    snap(96, 4, 4, 4, 19, 1, 0, 0, 0);
    snap(97, 3, 3, 3, 21, 0, 0, 1, 1);
    snap(100, 0, 0, 0, 27, 0, 0, 1, 1);
    snap(116, 0, 0, 0, 59, 0, 0, 1, 0);
    snap(128, 0, 0, 0, 23, 0, 0, 0, 0);
    snap(129, 0, 0, 0, 20, 1, 0, 0, 0);
    snap(135, 0, 0, 0, 2, 1, 0, 0, 0);
    snap(136, 0, 0, 0, 0, 1, 1, 0, 0);
    snap(138, 0, 0, 0, 0, 1, 1, 0, 0);
    exp_ack(4'b1000, 2'd3);
    release_reset();
    wait_tick(90);
    req = 4'b1000;
    wait_ack();
    req = 4'b0000;
    wait_tick(138);
    req = 4'b1111;          // dead: must never be acked
    wait_tick(141);
    req = 4'b0000;

    // sleep with saturation, cancel on a tick, then reset mid-action
    btn_reset = 1'b0;
    repeat (3) @(negedge clk);
    snap(1, 99, 99, 99, 100, 0, 0, 0, 0);
    snap(2, 98, 98, 100, 100, 0, 0, 1, 1);
    snap(3, 97, 97, 100, 100, 0, 0, 1, 0);
    exp_ack(4'b0100, 2'd2);
    exp_ack(4'b0001, 2'd0);
    release_reset();
    wait_tick(1);
    req = 4'b0100;
    wait_ack();
    req = 4'b0000;
    wait_tick(3);
    cancel = 1'b1;
    req = 4'b0001;
    step();
    cancel = 1'b0;
    wait_ack();
    req = 4'b0000;
    wait_tick(5);
    step();
    step();
    btn_reset = 1'b0;
    #1;
    check_reset("reset_mid_active");
    repeat (2) @(negedge clk);

    n_chk++;
    if (ackq.size() != 0 || snapq.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d acks and %0d snapshots still pending, required 0 and 0",
               ackq.size(), snapq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
